// File: rtl/aurora_link_supervisor.sv
// Reset sequencer and link-health monitor for a single-lane Aurora 64B/66B core:
// orders pma_init/reset_pb, retries bring-up on timeout, debounces channel drops.
module aurora_link_supervisor #(
    parameter int PMA_HOLD_CYC      = 128,
    parameter int RESET_PB_LAG_CYC  = 16,
    parameter int LINK_TIMEOUT_CYC  = 65536,
    parameter int DOWN_DEBOUNCE_CYC = 8,
    parameter int CNT_W             = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             enable,
    input  logic             force_reinit,
    input  logic             clr_stats,
    input  logic             channel_up,
    input  logic             lane_up,
    output logic             pma_init,
    output logic             reset_pb,
    output logic             link_ok,
    output logic             timeout_pulse,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] retry_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PMA_HOLD = 3'd1,
        PB_LAG   = 3'd2,
        WAIT_UP  = 3'd3,
        UP       = 3'd4,
        DOWN_CHK = 3'd5
    } state_t;

    localparam int MAX_AB = (PMA_HOLD_CYC > RESET_PB_LAG_CYC) ? PMA_HOLD_CYC : RESET_PB_LAG_CYC;
    localparam int MAX_CD = (LINK_TIMEOUT_CYC > DOWN_DEBOUNCE_CYC) ? LINK_TIMEOUT_CYC : DOWN_DEBOUNCE_CYC;
    localparam int MAX_LD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW     = (MAX_LD > 1) ? $clog2(MAX_LD) : 1;

    // Timer holds "cycles remaining after this one", so each load is N-1.
    localparam logic [TW-1:0] PMA_LD  = TW'(PMA_HOLD_CYC - 1);
    localparam logic [TW-1:0] LAG_LD  = TW'(RESET_PB_LAG_CYC - 1);
    localparam logic [TW-1:0] TO_LD   = TW'(LINK_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] DB_LD   = TW'(DOWN_DEBOUNCE_CYC - 1);

    state_t          state, nxt;
    logic [TW-1:0]   tmr, ld_val;
    logic            ch_s1, ch_s2, ln_s1, ln_s2;
    logic            up_s, tmr_zero, timeout_ev, drop_ev;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ch_s1 <= 1'b0;
            ch_s2 <= 1'b0;
            ln_s1 <= 1'b0;
            ln_s2 <= 1'b0;
        end else begin
            ch_s1 <= channel_up;
            ch_s2 <= ch_s1;
            ln_s1 <= lane_up;
            ln_s2 <= ln_s1;
        end
    end

    assign up_s     = ch_s2 & ln_s2;
    assign tmr_zero = (tmr == '0);

    always_comb begin
        nxt        = state;
        timeout_ev = 1'b0;
        drop_ev    = 1'b0;
        if (!enable) begin
            nxt = IDLE;
        end else if (force_reinit && (state == WAIT_UP || state == UP || state == DOWN_CHK)) begin
            nxt = PMA_HOLD;
        end else begin
            case (state)
                IDLE:     nxt = PMA_HOLD;
                PMA_HOLD: if (tmr_zero) nxt = PB_LAG;
                PB_LAG:   if (tmr_zero) nxt = WAIT_UP;
                WAIT_UP: begin
                    // A link that comes up on the final cycle beats the timeout.
                    if (up_s) nxt = UP;
                    else if (tmr_zero) begin
                        nxt        = PMA_HOLD;
                        timeout_ev = 1'b1;
                    end
                end
                UP:       if (!up_s) nxt = DOWN_CHK;
                DOWN_CHK: begin
                    if (up_s) nxt = UP;
                    else if (tmr_zero) begin
                        nxt     = PMA_HOLD;
                        drop_ev = 1'b1;
                    end
                end
                default:  nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ld_val = '0;
        case (nxt)
            PMA_HOLD: ld_val = PMA_LD;
            PB_LAG:   ld_val = LAG_LD;
            WAIT_UP:  ld_val = TO_LD;
            DOWN_CHK: ld_val = DB_LD;
            default:  ld_val = '0;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= IDLE;
            tmr           <= '0;
            timeout_pulse <= 1'b0;
            retry_count   <= '0;
            drop_count    <= '0;
        end else begin
            state         <= nxt;
            timeout_pulse <= timeout_ev;
            if (nxt != state)  tmr <= ld_val;
            else if (!tmr_zero) tmr <= tmr - 1'b1;
            if (clr_stats) retry_count <= '0;
            else if (timeout_ev && retry_count != '1) retry_count <= retry_count + 1'b1;
            if (clr_stats) drop_count <= '0;
            else if (drop_ev && drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

    always_comb begin
        pma_init = 1'b0;
        reset_pb = 1'b0;
        case (state)
            IDLE, PMA_HOLD: begin
                pma_init = 1'b1;
                reset_pb = 1'b1;
            end
            PB_LAG:  reset_pb = 1'b1;
            default: ;
        endcase
    end

    assign link_ok = (state == UP);
    assign state_o = state;

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// Directed bench for aurora_link_supervisor with short timings and a 4-bit
// counter width so saturation is reachable.
module tb_aurora_link_supervisor;

    localparam int CW = 4;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          enable, force_reinit, clr_stats, channel_up, lane_up;
    logic          pma_init, reset_pb, link_ok, timeout_pulse;
    logic [2:0]    state_o;
    logic [CW-1:0] drop_count, retry_count;

    int n_chk = 0;
    int n_err = 0;

    aurora_link_supervisor #(
        .PMA_HOLD_CYC      (8),
        .RESET_PB_LAG_CYC  (4),
        .LINK_TIMEOUT_CYC  (32),
        .DOWN_DEBOUNCE_CYC (4),
        .CNT_W             (CW)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .enable        (enable),
        .force_reinit  (force_reinit),
        .clr_stats     (clr_stats),
        .channel_up    (channel_up),
        .lane_up       (lane_up),
        .pma_init      (pma_init),
        .reset_pb      (reset_pb),
        .link_ok       (link_ok),
        .timeout_pulse (timeout_pulse),
        .state_o       (state_o),
        .drop_count    (drop_count),
        .retry_count   (retry_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic chk_io(input string tag, input int st, input int pi, input int rp);
        chk({tag, ".state"},    32'(state_o),  32'(st));
        chk({tag, ".pma_init"}, 32'(pma_init), 32'(pi));
        chk({tag, ".reset_pb"}, 32'(reset_pb), 32'(rp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ap_rst_n = 1'b0; enable = 1'b0; force_reinit = 1'b0; clr_stats = 1'b0;
        channel_up = 1'b0; lane_up = 1'b0;
        #23;
        chk_io("rst", 0, 1, 1);
        chk("rst.link_ok", 32'(link_ok), 0);
        chk("rst.timeout", 32'(timeout_pulse), 0);
        chk("rst.retry", 32'(retry_count), 0);
        chk("rst.drop", 32'(drop_count), 0);
        step(1);
        ap_rst_n = 1'b1;
        step(1);
        chk("idle_hold", 32'(state_o), 0);

        // Bring-up with no link: 8 cycles pma_init, 4 cycles reset_pb, 32 in WAIT_UP
        enable = 1'b1;
        step(1);  chk_io("pma_first", 1, 1, 1);
        step(7);  chk_io("pma_last", 1, 1, 1);
        step(1);  chk_io("lag_first", 2, 0, 1);
        step(3);  chk_io("lag_last", 2, 0, 1);
        step(1);  chk_io("wait_first", 3, 0, 0);
        chk("wait.link_ok", 32'(link_ok), 0);
        step(31); chk("wait_last.state", 32'(state_o), 3);
        chk("wait_last.timeout", 32'(timeout_pulse), 0);
        step(1);  chk_io("to1", 1, 1, 1);
        chk("to1.timeout", 32'(timeout_pulse), 1);
        chk("to1.retry", 32'(retry_count), 1);
        step(1);  chk("to1.pulse_width", 32'(timeout_pulse), 0);

        // Link comes up 10 cycles into WAIT_UP
        step(11); chk("wait2.state", 32'(state_o), 3);
        step(10);
        channel_up = 1'b1; lane_up = 1'b1;
        step(2);  chk("up_lat2.state", 32'(state_o), 3);
        chk("up_lat2.link_ok", 32'(link_ok), 0);
        step(1);  chk("up_lat3.state", 32'(state_o), 4);
        chk("up_lat3.link_ok", 32'(link_ok), 1);
        chk("up.retry", 32'(retry_count), 1);

        // Glitch shorter than debounce
        channel_up = 1'b0;
        step(3);  chk("glitch.state", 32'(state_o), 5);
        chk("glitch.link_ok", 32'(link_ok), 0);
        channel_up = 1'b1;
        step(2);  chk("glitch_hold.state", 32'(state_o), 5);
        step(1);  chk("glitch_back.state", 32'(state_o), 4);
        chk("glitch_back.link_ok", 32'(link_ok), 1);
        chk("glitch.drop", 32'(drop_count), 0);

        // Real drop
        channel_up = 1'b0;
        step(6);  chk("drop_pre.state", 32'(state_o), 5);
        chk("drop_pre.drop", 32'(drop_count), 0);
        step(1);  chk_io("drop", 1, 1, 1);
        chk("drop.count", 32'(drop_count), 1);
        channel_up = 1'b1;
        step(13); chk("relink.state", 32'(state_o), 4);

        // Forced reinit from UP
        force_reinit = 1'b1; channel_up = 1'b0; lane_up = 1'b0;
        step(1);
        force_reinit = 1'b0;
        chk("force.state", 32'(state_o), 1);
        chk("force.drop", 32'(drop_count), 1);
        chk("force.retry", 32'(retry_count), 1);

        // Clear on the same cycle as a timeout
        step(12); chk("clr_wait.state", 32'(state_o), 3);
        step(31);
        clr_stats = 1'b1;
        step(1);
        clr_stats = 1'b0;
        chk("clr.state", 32'(state_o), 1);
        chk("clr.timeout", 32'(timeout_pulse), 1);
        chk("clr.retry", 32'(retry_count), 0);
        chk("clr.drop", 32'(drop_count), 0);

        // Saturation of retry_count
        for (int i = 1; i <= 17; i++) begin
            step(12);
            step(31);
            chk("sat.wait_state", 32'(state_o), 3);
            step(1);
            chk("sat.timeout", 32'(timeout_pulse), 1);
            chk("sat.retry", 32'(retry_count), (i > 15) ? 32'd15 : 32'(i));
        end

        // enable dropped while in PB_LAG
        step(8);  chk("en_lag.state", 32'(state_o), 2);
        enable = 1'b0;
        step(1);  chk_io("en_off", 0, 1, 1);
        chk("en_off.retry", 32'(retry_count), 15);

        // Asynchronous reset in the middle of WAIT_UP
        enable = 1'b1;
        step(13); chk("arst_wait.state", 32'(state_o), 3);
        step(5);
        #3;
        ap_rst_n = 1'b0;
        #1;
        chk_io("arst", 0, 1, 1);
        chk("arst.link_ok", 32'(link_ok), 0);
        chk("arst.timeout", 32'(timeout_pulse), 0);
        chk("arst.retry", 32'(retry_count), 0);
        chk("arst.drop", 32'(drop_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
